mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 208 ++++++++++++++++++++
 tb/tb_mult_div.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// rtl/mult_div.sv - multi-cycle MIPS-style multiply/divide unit with HI/LO registers
//
// Purpose:
//   Executes MULT/MULTU and, when MDU_DIV_EN is defined, DIV/DIVU.
//   The result is computed when the operation is accepted and is held in
//   internal result registers. It is committed to HI/LO after a fixed busy
//   latency. MTHI/MTLO write the architectural registers directly.
//
// Configuration:
//   MDU_DIV_EN  defined   -> the divider is built and op 2/3 run DIV/DIVU.
//               undefined -> there is no divider; op 2/3 are no-ops.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   launch the operation selected by op (only accepted when idle)
//   op      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6/7=no-op
//   A       operand rs, or the write data for MTHI/MTLO
//   B       operand rt
//   cancel  abort the in-flight operation without committing it
//   busy    high while an operation is in flight
//   HI, LO  architectural HI/LO registers (direct register outputs)

module mult_div #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
`endif
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        skip_q, skip_d;    // divide by zero: run the latency but skip the commit
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // ------------------------------------------------------------------
    // Multiplier: the low 64 bits of a 64x64 product of sign-extended
    // operands equal the signed 32x32 product.
    // ------------------------------------------------------------------
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;

    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        prod   = (op == OP_MULT) ? prod_s : prod_u;
    end

    // Latency loaded into the counter; op[1] separates divides from multiplies.
    logic [3:0] cnt_load;
    assign cnt_load = op[1] ? DIV_CNT : MULT_CNT;

`ifdef MDU_DIV_EN
    // ------------------------------------------------------------------
    // Divider: unsigned divide of magnitudes, then sign fix-up.
    // The quotient truncates toward zero and the remainder follows the sign
    // of A. 0x80000000 / -1 wraps naturally to 0x80000000 with remainder 0.
    // ------------------------------------------------------------------
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe;
    logic [31:0] q_mag, r_mag;
    logic [31:0] quot, rem;
    logic        div_zero;

    always_comb begin
        div_signed = (op == OP_DIV);
        a_neg      = div_signed & A[31];
        b_neg      = div_signed & B[31];
        a_mag      = a_neg ? (32'd0 - A) : A;
        b_mag      = b_neg ? (32'd0 - B) : B;
        div_zero   = (B == 32'd0);
        // The divisor is forced nonzero so the datapath is always defined.
        // The result is discarded at commit anyway.
        b_safe     = div_zero ? 32'd1 : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem        = a_neg ? (32'd0 - r_mag) : r_mag;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        skip_d   = skip_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        unique case (state_q)
            ST_IDLE: begin
                // cancel takes priority over start, even when the unit is idle.
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = ST_MUL;
                            cnt_d    = cnt_load;
                            res_hi_d = prod[63:32];
                            res_lo_d = prod[31:0];
                            skip_d   = 1'b0;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            state_d  = ST_DIV;
                            cnt_d    = cnt_load;
                            res_hi_d = rem;
                            res_lo_d = quot;
                            skip_d   = div_zero;
                        end
`endif
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end

            ST_MUL, ST_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    if (!skip_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            skip_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            skip_q   <= skip_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// tb/tb_mult_div.sv - self-checking bench for mult_div

module tb_mult_div;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .cancel (cancel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    vec_t tbl [16];
    exp_t exp_q [$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, req);
    endtask

    // Called at a falling edge; returns at the falling edge after busy drops.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input int ecyc,
                         input string nm);
        exp_t e;
        int   n;
        exp_q.push_back('{eh, el, ecyc, nm});
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = 3'd7; A = '0; B = '0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        chk({e.name, "_busy_cycles"}, 32'(n), 32'(e.cyc));
        chk({e.name, "_hi"}, HI, e.hi);
        chk({e.name, "_lo"}, LO, e.lo);
    endtask

    localparam logic [31:0] HI_D = DIV_EN ? 32'h0000_0001 : 32'hA5A5_A5A5;
    localparam logic [31:0] LO_D = DIV_EN ? 32'hFFFF_FFFD : 32'h0000_5A5A;

    initial begin
        int n;

        tbl[0]  = '{3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, "mult_m1x2"};
        tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, "multu_maxx2"};
        tbl[2]  = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 5, "mult_min_sq"};
        tbl[3]  = '{3'd1, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 5, "multu_shift"};
        tbl[4]  = '{3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, "mult_m3x7"};
        tbl[5]  = '{3'd4, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 32'hFFFF_FFEB, 0, "mthi"};
        tbl[6]  = '{3'd5, 32'h0000_5A5A, 32'd0, 32'hA5A5_A5A5, 32'h0000_5A5A, 0, "mtlo"};
        tbl[7]  = '{3'd6, 32'h1111_1111, 32'd3, 32'hA5A5_A5A5, 32'h0000_5A5A, 0, "rsvd6"};
        tbl[8]  = '{3'd7, 32'h2222_2222, 32'd4, 32'hA5A5_A5A5, 32'h0000_5A5A, 0, "rsvd7"};
        tbl[9]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,
                    DIV_EN ? 32'hFFFF_FFFF : 32'hA5A5_A5A5,
                    DIV_EN ? 32'hFFFF_FFFD : 32'h0000_5A5A, DIV_EN ? 10 : 0, "div_m7by2"};
        tbl[10] = '{3'd3, 32'd7, 32'd0,
                    DIV_EN ? 32'hFFFF_FFFF : 32'hA5A5_A5A5,
                    DIV_EN ? 32'hFFFF_FFFD : 32'h0000_5A5A, DIV_EN ? 10 : 0, "divu_by0"};
        tbl[11] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                    DIV_EN ? 32'h0 : 32'hA5A5_A5A5,
                    DIV_EN ? 32'h8000_0000 : 32'h0000_5A5A, DIV_EN ? 10 : 0, "div_ovf"};
        tbl[12] = '{3'd3, 32'd8, 32'd2,
                    DIV_EN ? 32'h0 : 32'hA5A5_A5A5,
                    DIV_EN ? 32'h4 : 32'h0000_5A5A, DIV_EN ? 10 : 0, "divu_8by2"};
        tbl[13] = '{3'd2, 32'd7, 32'hFFFF_FFFE, HI_D, LO_D, DIV_EN ? 10 : 0, "div_7bym2"};
        tbl[14] = '{3'd4, 32'h0, 32'd0, 32'h0, LO_D, 0, "mthi_zero"};
        tbl[15] = '{3'd4, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, LO_D, 0, "mthi_a5"};

        start = 1'b0; op = 3'd7; A = '0; B = '0; cancel = 1'b0; reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);

        // Release reset and launch immediately: the first edge must accept it.
        reset = 1'b1;
        start = 1'b1; op = 3'd5; A = 32'h77;
        @(negedge clk);
        start = 1'b0;
        chk("first_start_lo", LO, 32'h77);
        chk("first_start_busy", 32'(busy), 32'd0);

        for (int i = 0; i < 16; i++)
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].cyc, tbl[i].name);

        // MTLO issued while a MULT is in flight must be ignored.
        start = 1'b1; op = 3'd0; A = 32'd3; B = 32'd5;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2) begin start = 1'b1; op = 3'd5; A = 32'h1234; end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        chk("overlap_busy_cycles", 32'(n), 32'd5);
        chk("overlap_hi", HI, 32'h0);
        chk("overlap_lo", LO, 32'hF);

        // Cancel mid-MULT: no commit now or later.
        do_op(3'd4, 32'h1111_1111, 32'd0, 32'h1111_1111, 32'hF, 0, "pre_cancel_mthi");
        do_op(3'd5, 32'h2222_2222, 32'd0, 32'h1111_1111, 32'h2222_2222, 0, "pre_cancel_mtlo");
        start = 1'b1; op = 3'd0; A = 32'd2; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", 32'(busy), 32'd0);
        chk("cancel_hi", HI, 32'h1111_1111);
        chk("cancel_lo", LO, 32'h2222_2222);
        repeat (8) @(negedge clk);
        chk("cancel_no_late_lo", LO, 32'h2222_2222);

        // cancel together with start in idle suppresses the start.
        cancel = 1'b1; start = 1'b1; op = 3'd4; A = 32'h99;
        @(negedge clk);
        cancel = 1'b0; start = 1'b0;
        chk("cancel_start_hi", HI, 32'h1111_1111);
        chk("cancel_start_busy", 32'(busy), 32'd0);

`ifdef MDU_DIV_EN
        start = 1'b1; op = 3'd3; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("div_cancel_busy", 32'(busy), 32'd0);
        chk("div_cancel_lo", LO, 32'h2222_2222);
        repeat (12) @(negedge clk);
        chk("div_cancel_no_late_hi", HI, 32'h1111_1111);
`endif

        // Asynchronous reset mid-MULT clears everything with no later commit.
        start = 1'b1; op = 3'd0; A = 32'd6; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_hi", HI, 32'h0);
        chk("midreset_lo", LO, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        chk("postreset_busy", 32'(busy), 32'd0);
        chk("postreset_lo", LO, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
